// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame/baud constants and the tx arbiter state encodings.
package uart_pkg;

  localparam int BPS_MAX = 5208;
  localparam int BIT_MAX = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    LOAD      = ST_LOAD,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE,
    GAP       = ST_GAP
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    sel,
  output logic             any_req
);

  logic [PW:0] idx;

  // One extra bit holds ptr+k before the modulo fold, so idx never exceeds N_REQ-1.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
      if (!any_req && req[idx[PW-1:0]]) begin
        any_req = 1'b1;
        sel     = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that grants one byte at a time to a shared UART transmitter,
// tracks the frame via tx_busy and then enforces an inter-frame gap.
module uart_tx_arb #(
  parameter int N_REQ   = 4,
  parameter int BIT_MAX = uart_pkg::BIT_MAX,
  parameter int ACK_TO  = 16,
  parameter int GAP_CYC = uart_pkg::BPS_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BIT_MAX-1:0] req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [BIT_MAX-1:0]       tx_data,
  output logic                     tx_ready,
  input  logic                     tx_busy,
  output logic                     drop,
  output logic                     err,
  output logic                     arb_busy,
  output logic [2:0]               state_dbg
);
  import uart_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TO - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

  // Handshakes: a requester holds req until it sees its one-cycle gnt pulse, which is
  // also the cycle its byte is captured. Toward the transmitter, tx_ready stays high
  // with tx_data stable until tx_busy is seen (acknowledge) or ACK_TO cycles elapse.
  arb_state_t        state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     sel;
  logic              any_req;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;
  logic [BIT_MAX-1:0] sel_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .sel     (sel),
    .any_req (any_req)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == PW'(i)) sel_data = req_data[i*BIT_MAX +: BIT_MAX];
    end
  end

  assign arb_busy  = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= PW'(N_REQ - 1);
      gnt      <= '0;
      tx_data  <= '0;
      tx_ready <= 1'b0;
      drop     <= 1'b0;
      err      <= 1'b0;
      tcnt     <= '0;
      gcnt     <= '0;
    end else begin
      gnt  <= '0;
      drop <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
            tx_data <= sel_data;
            ptr     <= sel;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // The transmitter never starts on 0x00, so such a byte is discarded here.
          if (tx_data == '0) begin
            drop  <= 1'b1;
            state <= IDLE;
          end else begin
            tx_ready <= 1'b1;
            tcnt     <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            tx_ready <= 1'b0;
            state    <= WAIT_DONE;
          end else if (tcnt == T_LAST) begin
            tx_ready <= 1'b0;
            err      <= 1'b1;
            gcnt     <= '0;
            state    <= GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            gcnt  <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (gcnt == G_LAST) state <= IDLE;
          else gcnt <= gcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
